instr_mem_prog: RTL
===================

Name: instr_mem_prog

Overview:
- Parametrised word-organised instruction memory for the 5-stage core, succeeding the fixed 256-byte reset-loaded ROM.
- Adds a sequential NOP-fill initialiser, a runtime program-load port with valid/ready handshake, and a registered fetch port with stall hold and fault reporting.
- Sits between PC generation (IF) and the IF/ID register. The program loader (testbench or debug host) writes through the load port.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; must be a power of two, >= 4
ADDR_W, $clog2(DEPTH_WORDS), word-address width (derived, not overridden)
NOP_WORD, 32'h00000013, fill value and fault/idle instruction (ADDI x0,x0,0)
RESET_PC, 32'h00000000, informational; fetch behaviour does not depend on it

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
clear_req  in  1  one-cycle pulse; re-runs NOP fill (accepted only in RUN)
init_done  out  1  high when memory is usable (state RUN or LOAD)
prog_en  in  1  level; requests/holds load mode
prog_valid  in  1  load word valid
prog_ready  out  1  load port can accept a word
prog_addr  in  ADDR_W  word index to write
prog_data  in  32  instruction word
fetch_req  in  1  fetch request for fetch_pc
fetch_pc  in  32  byte address
fetch_stall  in  1  hold fetch outputs (pipeline stall)
fetch_valid  out  1  fetch_instr is valid this cycle
fetch_instr  out  32  fetched instruction
fetch_fault  out  1  accompanies fetch_valid; misaligned or out-of-range PC

Behaviour:
- States: INIT, RUN, LOAD.
- Reset asserted (low), asynchronous:
  - state=INIT, fill counter=0.
  - init_done=0, prog_ready=0, fetch_valid=0, fetch_fault=0, fetch_instr=NOP_WORD.
- Reset mid-operation aborts any fill, load or fetch immediately. Memory contents are not cleared by reset; only the INIT sweep clears them.
- INIT:
  - Writes NOP_WORD to word[counter] each cycle; counter increments.
  - After word DEPTH_WORDS-1 is written, goes to RUN with counter=0. Total DEPTH_WORDS cycles.
  - init_done=0, prog_ready=0, fetch_valid=0. fetch_req, prog_en and clear_req are ignored.
- RUN:
  - clear_req=1 -> INIT. clear_req has priority over prog_en.
  - Otherwise prog_en=1 -> LOAD.
  - Fetch is serviced only in RUN.
- LOAD:
  - prog_ready=1.
  - prog_valid & prog_ready writes prog_data to word[prog_addr] at the clock edge.
  - prog_en=0 -> RUN on the next edge. A handshake in that same cycle is not accepted, because prog_ready is already 0 combinationally when prog_en=0.
  - fetch_valid=0 while in LOAD. clear_req is ignored.
- Fetch, 1-cycle latency, registered output:
  - In RUN with fetch_stall=0 and fetch_req=1, next cycle: fetch_valid=1.
  - fault = (fetch_pc[1:0]!=0) | (fetch_pc[31:2] >= DEPTH_WORDS).
  - On fault: fetch_fault=1, fetch_instr=NOP_WORD.
  - Otherwise: fetch_fault=0, fetch_instr={word[fetch_pc[ADDR_W+1:2]]}. Little-endian word; byte 0 is at bits [7:0].
- Fetch with fetch_stall=1: fetch_valid, fetch_instr and fetch_fault all hold their previous values. The stall takes precedence over fetch_req.
- Fetch with fetch_req=0 and no stall: fetch_valid=0, fetch_fault=0, fetch_instr holds.
- Leaving RUN (to INIT or LOAD): fetch_valid=0 and fetch_fault=0 on the next edge. This holds even if fetch_stall=1.
- Read-after-write: unaffected by design, since loads and fetches never occur in the same state.
- Memory is a plain array with no reset term, and is inferable as RAM.

Test Plan:
- Release reset with DEPTH_WORDS=64 -> init_done rises exactly 64 cycles later. Fetch pc=0x00 and pc=0xFC -> fetch_instr=0x00000013, fetch_fault=0, one cycle after the request.
- Load words 0x00A00093, 0x00A00113, 0x00208463 at addr 0..2, then prog_en=0 -> fetch pc=0x0,0x4,0x8 back-to-back returns those words on consecutive cycles with fetch_valid=1.
- Fetch pc=0x06 -> fetch_fault=1, instr=0x00000013. Fetch pc=0x100 (DEPTH 64) -> fetch_fault=1.
- During a valid fetch of 0x00A00113, assert fetch_stall for 3 cycles with fetch_pc changing -> outputs frozen at 0x00A00113/valid=1 throughout. Deassert the stall -> new pc is served next cycle.
- After load, pulse clear_req -> init_done=0 for 64 cycles. A subsequent fetch at pc=0x4 returns 0x00000013.
- Assert reset mid-INIT and mid-LOAD (prog_valid=1) -> all outputs take reset values asynchronously. Release -> full INIT sweep restarts from counter 0.

Source files
------------

// File: rtl/instr_mem_prog.sv
// Word-organised instruction memory with NOP-fill initialiser, runtime program-load port
// and a registered fetch port with stall hold and fault reporting.
module instr_mem_prog #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter logic [31:0] NOP_WORD    = 32'h00000013,
   parameter logic [31:0] RESET_PC    = 32'h00000000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear_req,
   output logic                           init_done,
   input  logic                           prog_en,
   input  logic                           prog_valid,
   output logic                           prog_ready,
   input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
   input  logic [31:0]                    prog_data,
   input  logic                           fetch_req,
   input  logic [31:0]                    fetch_pc,
   input  logic                           fetch_stall,
   output logic                           fetch_valid,
   output logic [31:0]                    fetch_instr,
   output logic                           fetch_fault
);

   localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 ||
       RESET_PC[1:0] != 2'b00) begin : g_param_check
      $error("instr_mem_prog: DEPTH_WORDS must be a power of two >= 4, RESET_PC word aligned");
   end

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              valid_q, valid_d;
   logic              fault_q, fault_d;
   logic [31:0]       instr_q, instr_d;
   logic              pc_fault;
   logic [ADDR_W-1:0] pc_idx;

   assign init_done  = (state_q == ST_RUN) || (state_q == ST_LOAD);
   assign prog_ready = (state_q == ST_LOAD) && prog_en;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = cnt_q;
      mem_wdata = NOP_WORD;
      case (state_q)
         ST_INIT: begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (clear_req) begin
               state_d = ST_INIT;
            end else if (prog_en) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (prog_valid && prog_ready) begin
               mem_we    = 1'b1;
               mem_waddr = prog_addr;
               mem_wdata = prog_data;
            end
            if (!prog_en) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // No reset term so the array maps to RAM; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (mem_we && reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign pc_fault = (fetch_pc[1:0] != 2'b00) || (|fetch_pc[31:ADDR_W+2]);
   assign pc_idx   = fetch_pc[ADDR_W+1:2];

   always_comb begin
      valid_d = valid_q;
      fault_d = fault_q;
      instr_d = instr_q;
      // Leaving RUN (or not in it) clears valid/fault even under stall.
      if (state_q != ST_RUN || state_d != ST_RUN) begin
         valid_d = 1'b0;
         fault_d = 1'b0;
      end else if (!fetch_stall) begin
         if (fetch_req) begin
            valid_d = 1'b1;
            fault_d = pc_fault;
            instr_d = pc_fault ? NOP_WORD : mem[pc_idx];
         end else begin
            valid_d = 1'b0;
            fault_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         instr_q <= NOP_WORD;
      end else begin
         valid_q <= valid_d;
         fault_q <= fault_d;
         instr_q <= instr_d;
      end
   end

   assign fetch_valid = valid_q;
   assign fetch_fault = fault_q;
   assign fetch_instr = instr_q;

endmodule
